// File: rtl/uart_tx_pkg.sv
// Shared definitions for the UART transmitter (and the matching receiver).
//   state_t        : frame state encoding IDLE/START/DATA/PARITY/STOP
//   LINE_IDLE      : level of the serial line between frames
//   START_BIT      : level driven during the start bit
//   STOP_BIT       : level driven during the stop bit(s)
//   frame_clks()   : clock cycles from acceptance to frame completion
package uart_tx_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } state_t;

  localparam logic LINE_IDLE = 1'b1;
  localparam logic START_BIT = 1'b0;
  localparam logic STOP_BIT  = 1'b1;

  function automatic int frame_clks(int clks_per_bit, int data_bits,
                                    int parity_en, int stop_bits);
    return (1 + data_bits + parity_en + stop_bits) * clks_per_bit;
  endfunction

endpackage

// File: rtl/uart_tx_if.sv
// Parallel-side handshake plus serial/status outputs of the UART transmitter.
//   data  : word to send (sampled on acceptance)
//   valid : data is valid
//   ready : transmitter can accept a word
//   tx    : serial line, idles high
//   busy  : frame in progress
//   done  : one-cycle pulse at frame completion
// master = word source, slave = transmitter.
interface uart_tx_if #(
  parameter int DATA_BITS = 8
);
  logic [DATA_BITS-1:0] data;
  logic                 valid;
  logic                 ready;
  logic                 tx;
  logic                 busy;
  logic                 done;

  modport master (output data, valid, input ready, tx, busy, done);
  modport slave  (input data, valid, output ready, tx, busy, done);
endinterface

// File: rtl/uart_baud_tick.sv
// Bit-period timer.
//   i_clk   : system clock
//   i_rst   : asynchronous active-high reset
//   i_clear : restart the bit period (counter back to zero)
//   o_tick  : high in the last cycle of each bit period
module uart_baud_tick #(
  parameter int CLKS_PER_BIT = 4
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_clear,
  output logic o_tick
);

  localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);

  logic [CW-1:0] cnt;

  // Reloads at the bit boundary, so it never runs past LAST.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst)                 cnt <= '0;
    else if (i_clear || o_tick) cnt <= '0;
    else                       cnt <= cnt + 1'b1;
  end

  assign o_tick = (cnt == LAST);

endmodule

// File: rtl/uart_tx.sv
// UART transmitter: start bit, DATA_BITS data bits LSB first, optional even
// parity, STOP_BITS stop bits.
//   i_clk : system clock, rising edge
//   i_rst : asynchronous active-high reset
//   bus   : uart_tx_if slave (data/valid/ready handshake, tx, busy, done)
module uart_tx
  import uart_tx_pkg::*;
#(
  parameter int CLKS_PER_BIT = 4,
  parameter int DATA_BITS    = 8,
  parameter int PARITY_EN    = 0,
  parameter int STOP_BITS    = 1
) (
  input  logic      i_clk,
  input  logic      i_rst,
  uart_tx_if.slave  bus
);

  if (CLKS_PER_BIT < 1 || DATA_BITS < 5 || DATA_BITS > 9 ||
      (PARITY_EN != 0 && PARITY_EN != 1) ||
      (STOP_BITS != 1 && STOP_BITS != 2)) begin : g_bad_params
    $error("uart_tx: illegal parameter value");
  end

  localparam int BW = $clog2(DATA_BITS + 1);
  localparam logic [BW-1:0] LAST_BIT  = BW'(DATA_BITS - 1);
  localparam logic          LAST_STOP = 1'(STOP_BITS - 1);

  state_t               state, state_nx;
  logic [BW-1:0]        bit_cnt;
  logic                 stop_cnt;
  logic                 armed;
  logic [DATA_BITS-1:0] shreg;
  logic                 par;
  logic                 tick;
  logic                 accept;
  logic                 last_stop;

  uart_baud_tick #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_baud (
    .i_clk   (i_clk),
    .i_rst   (i_rst),
    .i_clear (accept || (state == ST_IDLE)),
    .o_tick  (tick)
  );

  // Final cycle of the final stop bit: the frame completes here and a new
  // word can be taken on the closing edge, so frames abut with no idle gap.
  assign last_stop = (state == ST_STOP) && tick && (stop_cnt == LAST_STOP);
  assign accept    = bus.valid && bus.ready;

  assign bus.ready = armed && ((state == ST_IDLE) || last_stop);
  assign bus.done  = last_stop;
  assign bus.busy  = (state != ST_IDLE);

  always_comb begin
    case (state)
      ST_START:  bus.tx = START_BIT;
      ST_DATA:   bus.tx = shreg[0];
      ST_PARITY: bus.tx = par;
      ST_STOP:   bus.tx = STOP_BIT;
      default:   bus.tx = LINE_IDLE;
    endcase
  end

  always_comb begin
    state_nx = state;
    case (state)
      ST_IDLE:   if (accept) state_nx = ST_START;
      ST_START:  if (tick) state_nx = ST_DATA;
      ST_DATA:   if (tick && bit_cnt == LAST_BIT)
                   state_nx = (PARITY_EN != 0) ? ST_PARITY : ST_STOP;
      ST_PARITY: if (tick) state_nx = ST_STOP;
      ST_STOP:   if (last_stop) state_nx = accept ? ST_START : ST_IDLE;
      default:   state_nx = ST_IDLE;
    endcase
  end

  // Control state
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state    <= ST_IDLE;
      bit_cnt  <= '0;
      stop_cnt <= 1'b0;
      armed    <= 1'b0;
    end else begin
      state <= state_nx;
      armed <= 1'b1;
      if (state == ST_START && tick)     bit_cnt <= '0;
      else if (state == ST_DATA && tick) bit_cnt <= bit_cnt + 1'b1;
      if (last_stop)                      stop_cnt <= 1'b0;
      else if (state == ST_STOP && tick)  stop_cnt <= stop_cnt + 1'b1;
    end
  end

  // Datapath: word and its parity captured only on acceptance
  always_ff @(posedge i_clk) begin
    if (accept) begin
      shreg <= bus.data;
      par   <= ^bus.data;
    end else if (state == ST_DATA && tick) begin
      shreg <= shreg >> 1;
    end
  end

endmodule

// File: doc/uart_tx.md
Name: uart_tx

Overview:
- Serial transmitter for an 8N1-style asynchronous line; the transmit-side counterpart to the team's upcoming uart_rx sampler.
- Accepts one parallel word via a valid/ready handshake and shifts it out LSB first, framed by a start bit, optional even parity and stop bit(s).
- Sits between the cocotb-driven stimulus/logic side and the single-wire serial output.

Parameters:
- CLKS_PER_BIT, 4, clock cycles per bit period; legal range >= 1.
- DATA_BITS, 8, data bits per frame; legal range 5..9.
- PARITY_EN, 0, 1 inserts an even parity bit after the data bits.
- STOP_BITS, 1, stop bit count; legal values 1 or 2.

Ports:
- i_clk  input  1  system clock, rising-edge.
- i_rst  input  1  asynchronous, active-high reset.
- i_data  input  DATA_BITS  word to send; sampled only on acceptance.
- i_valid  input  1  i_data is valid.
- o_ready  output  1  transmitter can accept a word.
- o_tx  output  1  serial line; idles high.
- o_busy  output  1  frame in progress.
- o_done  output  1  one-cycle pulse at frame completion.

Behaviour:
- Reset (async, while i_rst=1): o_tx=1, o_ready=0, o_busy=0, o_done=0, state=IDLE, counters=0.
- After release, o_ready=1 in IDLE.
- All outputs are registered or decoded from state only; there is no combinational path from i_valid or i_data to any output.
- Acceptance is i_valid & o_ready at a rising edge. On that edge:
  - Latch i_data into the shift register.
  - Compute parity as the XOR of the data bits.
  - Go to START with o_tx=0, o_busy=1, o_ready=0.
- States and transitions:
  - IDLE -> START on acceptance.
  - START -> DATA after CLKS_PER_BIT cycles.
  - DATA emits DATA_BITS bits LSB first, each held CLKS_PER_BIT cycles. It then goes to PARITY if PARITY_EN=1, else to STOP.
  - PARITY drives the parity bit for one bit period, then goes to STOP.
  - STOP drives o_tx=1 for STOP_BITS bit periods, then goes to IDLE.
- On the STOP -> IDLE edge: o_done=1 for exactly one cycle, o_busy=0, o_ready=1.
- Frame length from the acceptance edge to o_done rising is (1 + DATA_BITS + PARITY_EN + STOP_BITS) * CLKS_PER_BIT cycles.
- Back-to-back transfers: a word presented during the o_done cycle is accepted on that edge. The minimum gap between frames is therefore 0 extra idle bit periods, since the stop bit serves as the separator.
- i_valid while o_ready=0 is ignored, with no queuing. i_data changes mid-frame do not affect the frame.
- Counters:
  - Baud counter is $clog2(CLKS_PER_BIT) bits wide (min 1). It reloads at each bit boundary and never wraps mid-bit.
  - Bit counter is $clog2(DATA_BITS+1) bits wide and resets on entry to DATA.
- CLKS_PER_BIT=1: each bit lasts one cycle; the same state sequence applies.
- Reset mid-frame: o_tx returns to 1 immediately (async), the frame is abandoned, and no o_done is generated.
- Illegal parameter values are rejected by an elaboration-time check.

Decomposition:
- Shared include uart_defs.vh, reused by uart_rx:
  - State encodings IDLE/START/DATA/PARITY/STOP as localparams.
  - Line idle level.
  - Start and stop bit values.
  - Frame-length helper macro.
- One sub-module, uart_baud_tick(CLKS_PER_BIT):
  - Inputs: i_clk, i_rst, i_clear.
  - Output: o_tick, pulsed at the end of each bit period.
  - i_clear restarts the period on acceptance.

Test Plan (CLKS_PER_BIT=4, DATA_BITS=8):
- Reset hold, then release -> o_tx=1, o_busy=0, o_ready=1 on the first edge after release.
- Send 0xA5 with PARITY_EN=0 -> o_tx bit sequence 0,1,0,1,0,0,1,0,1,1, each held 4 cycles. o_done pulses exactly 40 cycles after acceptance.
- Send 0xA5 then 0x3C back-to-back with i_valid held -> 0x3C accepted in the o_done cycle, its start bit immediately follows the stop bit, 80 cycles total.
- PARITY_EN=1, send 0x07 -> parity bit 1 after the data bits. Send 0x03 -> parity bit 0. Frame length 44 cycles.
- Assert i_rst during data bit 3 of 0xFF -> o_tx=1 within the same cycle. No o_done pulse. The next word sends a clean full frame.
- Toggle i_valid and i_data mid-frame -> no extra acceptance and the serial bits are unchanged. STOP_BITS=2 variant: stop high for 8 cycles.
